rf_banked_nrmw: RTL and testbench
=================================

RF_BANKED_NRMW -- requirements
Module: rf_banked_nrmw

Interface
REQ-001 SHALL have parameter WIDTH, default 64, data bits per entry.
REQ-002 SHALL have parameter LG_DEPTH, default 7, log2 of total entries.
REQ-003 SHALL have parameter LG_BANKS, default 1, log2 of bank count (NB = 1<<LG_BANKS, 1..8); one write port per bank.
REQ-004 SHALL have parameter N_RD, default 6, read port count (1..8).
REQ-005 SHALL have parameter BYPASS, default 1, meaning 1 = same-cycle write-to-read forwarding enabled.
REQ-006 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-007 SHALL have port reset  input  1  reset, which is asynchronous and active-low.
REQ-008 SHALL have port rdptr  input  N_RD x LG_DEPTH  read addresses, sampled every cycle.
REQ-009 SHALL have port wen  input  NB  write enable per bank port.
REQ-010 SHALL have port wrptr  input  NB x LG_DEPTH  write address per bank port.
REQ-011 SHALL have port wr  input  NB x WIDTH  write data per bank port.
REQ-012 SHALL have port rd  output  N_RD x WIDTH  registered read data.
REQ-013 SHALL have port ready  output  1  high once the init sweep completes.
REQ-014 SHALL have port bank_err  output  1  sticky flag for a misrouted write.

Function
REQ-015 Bank of an address SHALL be addr[LG_DEPTH-1 -: LG_BANKS]; the index within the bank SHALL be the remaining low bits; each bank holds 1<<(LG_DEPTH-LG_BANKS) entries.
REQ-016 Read latency SHALL be exactly 1 cycle: rd[i] in cycle t+1 reflects rdptr[i] sampled in cycle t.
REQ-017 Address 0 SHALL always read as 0, and writes to address 0 SHALL be discarded.
REQ-018 Write port b SHALL write only when wen[b]=1, ready=1 and the bank of wrptr[b] equals b.
REQ-019 A write with wen[b]=1, ready=1 and bank of wrptr[b] != b SHALL be dropped and SHALL set bank_err, which stays 1 until reset.
REQ-020 With BYPASS=1, if rdptr[i] equals an accepted write address in the same cycle, rd[i] next cycle SHALL equal that write's data; with BYPASS=0 it SHALL return the prior contents.
REQ-021 All N_RD reads SHALL be independent; any number of ports may read the same address in one cycle.
REQ-022 State machine SHALL have states INIT and RUN; reset forces INIT with sweep index 0.
REQ-023 In INIT, every bank SHALL write 0 to its entry at the sweep index each cycle, and the index SHALL increment by 1.
REQ-024 When the sweep index reaches the last entry and that entry is written, the FSM SHALL move to RUN, and ready SHALL go to 1 on the following cycle.
REQ-025 ready SHALL be 0 throughout INIT.
REQ-026 While ready=0, user writes SHALL be ignored, bank_err SHALL NOT change, and rd SHALL read 0.
REQ-027 RUN SHALL be terminal; only reset returns the FSM to INIT.

Reset
REQ-028 While reset=0: rd = 0, ready = 0, bank_err = 0, state = INIT, sweep index = 0.
REQ-029 Reset asserted mid-sweep or mid-operation SHALL abort immediately; after release the full sweep SHALL restart from index 0.
REQ-030 Array contents SHALL NOT be reset directly; they SHALL be cleared only by the INIT sweep.

Structure
REQ-031 Shared package rf_pkg SHALL hold the rf_state_t enum (INIT, RUN) and a bank-select helper function.
REQ-032 Sub-module rf_bank SHALL implement one bank: N_RD registered reads, one write port, and an init-clear input; the top SHALL instantiate NB copies plus the FSM, address decode, the zero and bypass muxing, and bank_err.

Verification
REQ-033 Release reset, hold all wen=0 -> ready rises exactly (1<<(LG_DEPTH-LG_BANKS))+1 cycles later; all 128 addresses then read 0.
REQ-034 After ready: write 0xDEADBEEF to addr 5 (port 0) and 0x1234 to addr 69 (port 1) in the same cycle; read both next cycle -> rd = 0xDEADBEEF and 0x1234 one cycle later.
REQ-035 BYPASS=1: write 0xAA to addr 7 while rdptr[3]=7 in the same cycle -> rd[3]=0xAA next cycle; BYPASS=0 -> previous value.
REQ-036 Write 0xFF to addr 0 -> a later read of addr 0 returns 0.
REQ-037 wen[0]=1 with wrptr[0]=70 -> no array change and bank_err=1; it stays 1 until reset.
REQ-038 Assert reset at sweep index 30, then release -> ready=0 until a full new sweep completes, and entries written before the reset read 0.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared types and helpers for the banked multi-read register file.
package rf_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } rf_state_t;

  // Bank number of an address: the top lg_banks bits of an lg_depth-bit address.
  function automatic int unsigned bank_sel(input logic [31:0]  addr,
                                           input int unsigned  lg_depth,
                                           input int unsigned  lg_banks);
    return (addr >> (lg_depth - lg_banks)) & ((32'd1 << lg_banks) - 32'd1);
  endfunction

endpackage

// File: rtl/rf_bank.sv
// One register-file bank: N_RD registered read ports, one write port and an init-clear port.
module rf_bank #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned LG_ENT = 6,
  parameter int unsigned N_RD   = 6
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [N_RD-1:0][LG_ENT-1:0]    rd_idx_i,
  output logic [N_RD-1:0][WIDTH-1:0]     rd_data_o,
  input  logic                           we_i,
  input  logic [LG_ENT-1:0]              wr_idx_i,
  input  logic [WIDTH-1:0]               wr_data_i,
  input  logic                           clr_i,
  input  logic [LG_ENT-1:0]              clr_idx_i
);

  logic [WIDTH-1:0]              mem_q [1<<LG_ENT];
  logic [N_RD-1:0][WIDTH-1:0]    rd_q;

  // Storage has no reset; it is cleared only by the init sweep.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      mem_q[clr_idx_i] <= '0;
    end else if (we_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q <= '0;
    end else begin
      for (int unsigned i = 0; i < N_RD; i++) begin
        rd_q[i] <= mem_q[rd_idx_i[i]];
      end
    end
  end

  assign rd_data_o = rd_q;

endmodule

// File: rtl/rf_banked_nrmw.sv
// Banked register file: NB write ports (one per bank), N_RD read ports, zero register, init sweep.
module rf_banked_nrmw
  import rf_pkg::*;
#(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned LG_DEPTH = 7,
  parameter int unsigned LG_BANKS = 1,
  parameter int unsigned N_RD     = 6,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [N_RD-1:0][LG_DEPTH-1:0]          rdptr,
  input  logic [(1<<LG_BANKS)-1:0]               wen,
  input  logic [(1<<LG_BANKS)-1:0][LG_DEPTH-1:0] wrptr,
  input  logic [(1<<LG_BANKS)-1:0][WIDTH-1:0]    wr,
  output logic [N_RD-1:0][WIDTH-1:0]             rd,
  output logic                                   ready,
  output logic                                   bank_err
);

  localparam int unsigned NB     = 1 << LG_BANKS;
  localparam int unsigned LG_ENT = LG_DEPTH - LG_BANKS;
  localparam int unsigned SW     = (LG_BANKS > 0) ? LG_BANKS : 1;

  rf_state_t            state_q;
  logic [LG_ENT-1:0]    idx_q;
  logic                 ready_q;
  logic                 bank_err_q;

  logic [NB-1:0]        acc, mis;
  logic [N_RD-1:0][LG_ENT-1:0] rd_idx;
  logic [N_RD-1:0][WIDTH-1:0]  bank_rd [NB];

  logic [N_RD-1:0][SW-1:0]     rsel_d, rsel_q;
  logic [N_RD-1:0]             zero_d, zero_q, byp_d, byp_q;
  logic [N_RD-1:0][WIDTH-1:0]  bypd_d, bypd_q;

  always_comb begin
    acc = '0;
    mis = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      if (wen[b] && ready_q) begin
        if (bank_sel(32'(wrptr[b]), LG_DEPTH, LG_BANKS) == b) begin
          acc[b] = (wrptr[b] != '0);
        end else begin
          mis[b] = 1'b1;
        end
      end
    end
  end

  // Only an accepted write can forward, so at most one bank matches per read port.
  always_comb begin
    rsel_d = '0;
    zero_d = '0;
    byp_d  = '0;
    bypd_d = '0;
    rd_idx = '0;
    for (int unsigned i = 0; i < N_RD; i++) begin
      rd_idx[i] = rdptr[i][LG_ENT-1:0];
      rsel_d[i] = SW'(bank_sel(32'(rdptr[i]), LG_DEPTH, LG_BANKS));
      zero_d[i] = !ready_q || (rdptr[i] == '0);
      if (BYPASS != 0) begin
        for (int unsigned b = 0; b < NB; b++) begin
          if (acc[b] && (wrptr[b] == rdptr[i])) begin
            byp_d[i]  = 1'b1;
            bypd_d[i] = wr[b];
          end
        end
      end
    end
  end

  for (genvar b = 0; b < NB; b++) begin : g_bank
    rf_bank #(
      .WIDTH (WIDTH),
      .LG_ENT(LG_ENT),
      .N_RD  (N_RD)
    ) u_bank (
      .clk_i    (clk),
      .rst_ni   (reset),
      .rd_idx_i (rd_idx),
      .rd_data_o(bank_rd[b]),
      .we_i     (acc[b]),
      .wr_idx_i (wrptr[b][LG_ENT-1:0]),
      .wr_data_i(wr[b]),
      .clr_i    (state_q == INIT),
      .clr_idx_i(idx_q)
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= INIT;
      idx_q      <= '0;
      ready_q    <= 1'b0;
      bank_err_q <= 1'b0;
    end else begin
      unique case (state_q)
        INIT: begin
          idx_q <= idx_q + 1'b1;
          if (idx_q == '1) state_q <= RUN;
        end
        RUN: ;
        default: state_q <= INIT;
      endcase
      ready_q    <= (state_q == RUN);
      bank_err_q <= bank_err_q | (|mis);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsel_q <= '0;
      zero_q <= '1;
      byp_q  <= '0;
      bypd_q <= '0;
    end else begin
      rsel_q <= rsel_d;
      zero_q <= zero_d;
      byp_q  <= byp_d;
      bypd_q <= bypd_d;
    end
  end

  always_comb begin
    rd = '0;
    for (int unsigned i = 0; i < N_RD; i++) begin
      if (zero_q[i])     rd[i] = '0;
      else if (byp_q[i]) rd[i] = bypd_q[i];
      else               rd[i] = bank_rd[rsel_q[i]][i];
    end
  end

  assign ready    = ready_q;
  assign bank_err = bank_err_q;

endmodule

// File: tb/tb_rf_banked_nrmw.sv
// Directed self-checking bench for rf_banked_nrmw at default parameters.
module tb_rf_banked_nrmw;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [5:0][6:0]      rdptr;
  logic [1:0]           wen;
  logic [1:0][6:0]      wrptr;
  logic [1:0][63:0]     wr;
  logic [5:0][63:0]     rd;
  logic                 ready;
  logic                 bank_err;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc;

  rf_banked_nrmw dut (
    .clk     (clk),
    .reset   (reset),
    .rdptr   (rdptr),
    .wen     (wen),
    .wrptr   (wrptr),
    .wr      (wr),
    .rd      (rd),
    .ready   (ready),
    .bank_err(bank_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    cyc = 0;
    while (!ready && cyc < 200) begin
      step();
      cyc++;
      if (cyc == 10) check_eq({tag, "_rd_during_init"}, rd[0], 64'h0);
      if (cyc == 64) check_eq({tag, "_ready_low_late"}, 64'(ready), 64'h0);
    end
    check_eq({tag, "_ready_latency"}, 64'(cyc), 64'd65);
  endtask

  initial begin
    reset = 1'b0;
    rdptr = '0;
    wen   = '0;
    wrptr = '0;
    wr    = '0;
    repeat (3) step();
    check_eq("rst_rd0", rd[0], 64'h0);
    check_eq("rst_ready", 64'(ready), 64'h0);
    check_eq("rst_bank_err", 64'(bank_err), 64'h0);

    rdptr[0] = 7'd5;
    reset = 1'b1;
    wait_ready("sweep1");

    // every address reads zero after the sweep
    for (int a = 0; a < 128; a += 6) begin
      for (int p = 0; p < 6; p++) rdptr[p] = 7'(a + p);
      step();
      for (int p = 0; p < 6; p++) check_eq("init_zero", rd[p], 64'h0);
    end

    // two-bank same-cycle writes
    wen = 2'b11;
    wrptr[0] = 7'd5;  wr[0] = 64'hDEADBEEF;
    wrptr[1] = 7'd69; wr[1] = 64'h1234;
    step();
    wrptr[0] = 7'd50;  wr[0] = 64'h5050;
    wrptr[1] = 7'd120; wr[1] = 64'h1200;
    rdptr[0] = 7'd5; rdptr[1] = 7'd69;
    step();
    wen = 2'b00;
    check_eq("wr_addr5", rd[0], 64'hDEADBEEF);
    check_eq("wr_addr69", rd[1], 64'h1234);
    rdptr[0] = 7'd50; rdptr[1] = 7'd120;
    step();
    check_eq("wr_addr50", rd[0], 64'h5050);
    check_eq("wr_addr120", rd[1], 64'h1200);

    // same-cycle forwarding plus shared-address reads
    wen = 2'b01; wrptr[0] = 7'd7; wr[0] = 64'hAA;
    rdptr[3] = 7'd7; rdptr[2] = 7'd5; rdptr[4] = 7'd69; rdptr[5] = 7'd69;
    step();
    wen = 2'b00;
    check_eq("bypass_rd3", rd[3], 64'hAA);
    check_eq("other_rd2", rd[2], 64'hDEADBEEF);
    check_eq("shared_rd4", rd[4], 64'h1234);
    check_eq("shared_rd5", rd[5], 64'h1234);
    step();
    check_eq("stored_addr7", rd[3], 64'hAA);

    // zero register
    wen = 2'b01; wrptr[0] = 7'd0; wr[0] = 64'hFF; rdptr[0] = 7'd0;
    step();
    wen = 2'b00;
    check_eq("addr0_same_cycle", rd[0], 64'h0);
    step();
    check_eq("addr0_later", rd[0], 64'h0);
    check_eq("addr0_no_err", 64'(bank_err), 64'h0);

    // misrouted write: addr 70 belongs to bank 1, not port 0
    wen = 2'b01; wrptr[0] = 7'd70; wr[0] = 64'h55; rdptr[0] = 7'd70;
    step();
    wen = 2'b00;
    rdptr[1] = 7'd6;
    check_eq("misroute_no_bypass", rd[0], 64'h0);
    check_eq("misroute_err", 64'(bank_err), 64'h1);
    step();
    check_eq("misroute_addr70", rd[0], 64'h0);
    check_eq("misroute_addr6", rd[1], 64'h0);
    repeat (5) step();
    check_eq("err_sticky", 64'(bank_err), 64'h1);

    // reset mid-sweep, with user writes attempted during INIT
    reset = 1'b0;
    #1;
    check_eq("rst2_err_clear", 64'(bank_err), 64'h0);
    check_eq("rst2_ready", 64'(ready), 64'h0);
    step();
    reset = 1'b1;
    repeat (20) step();
    wen = 2'b11; wrptr[0] = 7'd9; wr[0] = 64'h99; wrptr[1] = 7'd5; wr[1] = 64'h77;
    step();
    wen = 2'b00;
    check_eq("init_wr_no_err", 64'(bank_err), 64'h0);
    repeat (9) step();
    reset = 1'b0;
    #1;
    check_eq("abort_ready", 64'(ready), 64'h0);
    check_eq("abort_rd", rd[3], 64'h0);
    step();
    reset = 1'b1;
    wait_ready("sweep2");
    rdptr[0] = 7'd5;  rdptr[1] = 7'd69; rdptr[2] = 7'd7;
    rdptr[3] = 7'd50; rdptr[4] = 7'd120; rdptr[5] = 7'd9;
    step();
    check_eq("resweep_addr5", rd[0], 64'h0);
    check_eq("resweep_addr69", rd[1], 64'h0);
    check_eq("resweep_addr7", rd[2], 64'h0);
    check_eq("resweep_addr50", rd[3], 64'h0);
    check_eq("resweep_addr120", rd[4], 64'h0);
    check_eq("resweep_addr9", rd[5], 64'h0);
    check_eq("resweep_err", 64'(bank_err), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
